// File: rtl/mips_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit.
package mips_pkg;

    typedef enum logic [3:0] {
        S_START,
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXEC,
        S_ALUWB,
        S_ADDIEX,
        S_ADDIWB,
        S_BRANCH,
        S_JUMP,
        S_ILLEGAL,
        S_ERROR
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

endpackage

// File: rtl/mips_mc_waitcnt.sv
// Memory-wait counter; expire fires when the wait limit is reached with ready still low.
module mips_mc_waitcnt #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);
    localparam int W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYCLES);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + W'(1);
        end
    end

    // en already excludes ready, so a same-cycle ready always beats the limit
    assign expire = (TIMEOUT_CYCLES != 0) && en && (count == LIMIT);

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS control unit: Moore FSM over a shared datapath and memory port,
// with a ready handshake and a sticky bus error on wait timeout.
module mips_mc_ctrl
    import mips_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 15,
    parameter bit BNE_EN         = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [5:0] i_opcode,
    input  logic       i_zero,
    input  logic       i_mem_ready,
    output logic       o_mem_read,
    output logic       o_mem_write,
    output logic       o_iord,
    output logic       o_ir_write,
    output logic       o_pc_write,
    output logic [1:0] o_pc_src,
    output logic       o_alu_src_a,
    output logic [1:0] o_alu_src_b,
    output logic [1:0] o_alu_op,
    output logic       o_ext_op,
    output logic       o_reg_write,
    output logic       o_reg_dst,
    output logic       o_mem_to_reg,
    output logic       o_retire,
    output logic       o_illegal,
    output logic       o_bus_err
);
    // state   | meaning
    // FETCH   | read instr, PC+=4 on ready     DECODE | dispatch, precompute branch target
    // MEMADR  | lw/sw address                  MEMRD/MEMWR | data access, wait on ready
    // *WB     | register writeback, retire     BRANCH/JUMP | PC update, retire
    // ILLEGAL | skip unknown opcode            ERROR | bus timeout, exit by reset only
    state_t      state;
    logic [5:0]  op_q;
    logic        bus_err;
    logic        wait_state;
    logic        expire;

    assign wait_state = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);

    mips_mc_waitcnt #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_waitcnt (
        .clk    (i_clk),
        .rst_n  (i_rst_n),
        .clr    (!wait_state || i_mem_ready),
        .en     (wait_state && !i_mem_ready),
        .expire (expire)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= S_START;
            op_q    <= OP_RTYPE;
            bus_err <= 1'b0;
        end else begin
            if (expire) bus_err <= 1'b1;
            case (state)
                S_START:  state <= S_FETCH;
                S_FETCH:  if (expire) state <= S_ERROR; else if (i_mem_ready) state <= S_DECODE;
                S_DECODE: begin
                    op_q <= i_opcode;
                    case (i_opcode)
                        OP_RTYPE:     state <= S_EXEC;
                        OP_LW, OP_SW: state <= S_MEMADR;
                        OP_BEQ:       state <= S_BRANCH;
                        OP_BNE:       state <= BNE_EN ? S_BRANCH : S_ILLEGAL;
                        OP_J:         state <= S_JUMP;
                        OP_ADDI:      state <= S_ADDIEX;
                        default:      state <= S_ILLEGAL;
                    endcase
                end
                S_MEMADR: state <= (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
                S_MEMRD:  if (expire) state <= S_ERROR; else if (i_mem_ready) state <= S_MEMWB;
                S_MEMWR:  if (expire) state <= S_ERROR; else if (i_mem_ready) state <= S_FETCH;
                S_EXEC:   state <= S_ALUWB;
                S_ADDIEX: state <= S_ADDIWB;
                S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP, S_ILLEGAL: state <= S_FETCH;
                S_ERROR:  state <= S_ERROR;
                default:  state <= S_START;
            endcase
        end
    end

    assign o_bus_err = bus_err;

    always_comb begin
        o_mem_read   = 1'b0;
        o_mem_write  = 1'b0;
        o_iord       = 1'b0;
        o_ir_write   = 1'b0;
        o_pc_write   = 1'b0;
        o_pc_src     = PC_SRC_ALU;
        o_alu_src_a  = 1'b0;
        o_alu_src_b  = SRCB_REG;
        o_alu_op     = ALU_ADD;
        o_ext_op     = 1'b0;
        o_reg_write  = 1'b0;
        o_reg_dst    = 1'b0;
        o_mem_to_reg = 1'b0;
        o_retire     = 1'b0;
        o_illegal    = 1'b0;
        case (state)
            S_FETCH: begin
                o_mem_read  = 1'b1;
                o_alu_src_b = SRCB_FOUR;
                o_ir_write  = i_mem_ready;
                o_pc_write  = i_mem_ready;
            end
            S_DECODE: begin
                o_alu_src_b = SRCB_IMM_SH;
                o_ext_op    = 1'b1;
            end
            S_MEMADR, S_ADDIEX: begin
                o_alu_src_a = 1'b1;
                o_alu_src_b = SRCB_IMM;
                o_ext_op    = 1'b1;
            end
            S_MEMRD: begin
                o_mem_read = 1'b1;
                o_iord     = 1'b1;
            end
            S_MEMWB: begin
                o_reg_write  = 1'b1;
                o_mem_to_reg = 1'b1;
                o_retire     = 1'b1;
            end
            S_MEMWR: begin
                o_mem_write = 1'b1;
                o_iord      = 1'b1;
                o_retire    = i_mem_ready;
            end
            S_EXEC: begin
                o_alu_src_a = 1'b1;
                o_alu_op    = ALU_FUNCT;
            end
            S_ALUWB: begin
                o_reg_write = 1'b1;
                o_reg_dst   = 1'b1;
                o_retire    = 1'b1;
            end
            S_ADDIWB: begin
                o_reg_write = 1'b1;
                o_retire    = 1'b1;
            end
            S_BRANCH: begin
                o_alu_src_a = 1'b1;
                o_alu_op    = ALU_SUB;
                o_pc_src    = PC_SRC_ALUOUT;
                o_pc_write  = (op_q == OP_BNE) ? !i_zero : i_zero;
                o_retire    = 1'b1;
            end
            S_JUMP: begin
                o_pc_src   = PC_SRC_JUMP;
                o_pc_write = 1'b1;
                o_retire   = 1'b1;
            end
            S_ILLEGAL: o_illegal = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Directed bench for mips_mc_ctrl: full output vector checked every cycle against hand-built state vectors.
module tb_mips_mc_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [5:0] opcode = 6'h00;
    logic       zero = 1'b0;
    logic       ready = 1'b1;
    int         n_checks = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    logic a_mr, a_mw, a_io, a_irw, a_pcw, a_asa, a_ext, a_rw, a_rd, a_m2r, a_ret, a_ill, a_be;
    logic [1:0] a_ps, a_asb, a_aop;
    logic b_mr, b_mw, b_io, b_irw, b_pcw, b_asa, b_ext, b_rw, b_rd, b_m2r, b_ret, b_ill, b_be;
    logic [1:0] b_ps, b_asb, b_aop;

    mips_mc_ctrl #(.TIMEOUT_CYCLES(3), .BNE_EN(1'b1)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_opcode(opcode), .i_zero(zero), .i_mem_ready(ready),
        .o_mem_read(a_mr), .o_mem_write(a_mw), .o_iord(a_io), .o_ir_write(a_irw),
        .o_pc_write(a_pcw), .o_pc_src(a_ps), .o_alu_src_a(a_asa), .o_alu_src_b(a_asb),
        .o_alu_op(a_aop), .o_ext_op(a_ext), .o_reg_write(a_rw), .o_reg_dst(a_rd),
        .o_mem_to_reg(a_m2r), .o_retire(a_ret), .o_illegal(a_ill), .o_bus_err(a_be)
    );

    mips_mc_ctrl #(.TIMEOUT_CYCLES(15), .BNE_EN(1'b0)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_opcode(opcode), .i_zero(zero), .i_mem_ready(ready),
        .o_mem_read(b_mr), .o_mem_write(b_mw), .o_iord(b_io), .o_ir_write(b_irw),
        .o_pc_write(b_pcw), .o_pc_src(b_ps), .o_alu_src_a(b_asa), .o_alu_src_b(b_asb),
        .o_alu_op(b_aop), .o_ext_op(b_ext), .o_reg_write(b_rw), .o_reg_dst(b_rd),
        .o_mem_to_reg(b_m2r), .o_retire(b_ret), .o_illegal(b_ill), .o_bus_err(b_be)
    );

    logic [18:0] outs_a, outs_b;
    assign outs_a = {a_mr, a_mw, a_io, a_irw, a_pcw, a_ps, a_asa, a_asb, a_aop,
                     a_ext, a_rw, a_rd, a_m2r, a_ret, a_ill, a_be};
    assign outs_b = {b_mr, b_mw, b_io, b_irw, b_pcw, b_ps, b_asa, b_asb, b_aop,
                     b_ext, b_rw, b_rd, b_m2r, b_ret, b_ill, b_be};

    function automatic logic [18:0] pk(input int mr, mw, io, irw, pcw, ps, asa, asb, aop,
                                       input int ext, rw, rd, m2r, ret, ill, be);
        return {mr[0], mw[0], io[0], irw[0], pcw[0], ps[1:0], asa[0], asb[1:0], aop[1:0],
                ext[0], rw[0], rd[0], m2r[0], ret[0], ill[0], be[0]};
    endfunction

    logic [18:0] V_F0, V_F1, V_DEC, V_EXEC, V_ALUWB, V_MEMADR, V_MR, V_MEMWB, V_MW0, V_MW1;
    logic [18:0] V_ADDIWB, V_BR_T, V_BR_N, V_JUMP, V_ILL, V_ERR;

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if (outs_a !== 19'h0) begin n_fail++; $display("FAIL reset_async got %h expected %h", outs_a, 19'h0); end
        @(posedge clk); @(posedge clk); #1;
        n_checks++;
        if (outs_b !== 19'h0) begin n_fail++; $display("FAIL reset_b got %h expected %h", outs_b, 19'h0); end
        rst_n = 1'b1; ready = 1'b1; opcode = 6'h00;
        #1;
        n_checks++;
        if (outs_a !== 19'h0) begin n_fail++; $display("FAIL reset_start got %h expected %h", outs_a, 19'h0); end
        @(posedge clk); #1;
    endtask

    task automatic test_rtype();
        logic [18:0] ev [4];
        ev = '{V_F1, V_DEC, V_EXEC, V_ALUWB};
        opcode = 6'h00;
        for (int i = 0; i < 4; i++) begin
            ready = 1'b1; #1;
            n_checks++;
            if (outs_a !== ev[i]) begin n_fail++; $display("FAIL rtype cyc%0d got %h expected %h", i, outs_a, ev[i]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_lw_wait();
        logic [18:0] ev [9];
        bit rd [9];
        ev = '{V_F0, V_F0, V_F1, V_DEC, V_MEMADR, V_MR, V_MR, V_MR, V_MEMWB};
        rd = '{0, 0, 1, 1, 1, 0, 0, 1, 1};
        opcode = 6'h23;
        for (int i = 0; i < 9; i++) begin
            ready = rd[i]; #1;
            n_checks++;
            if (outs_a !== ev[i]) begin n_fail++; $display("FAIL lw_wait cyc%0d got %h expected %h", i, outs_a, ev[i]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_sw_addi();
        logic [18:0] ev [8];
        logic [5:0] op [8];
        ev = '{V_F1, V_DEC, V_MEMADR, V_MW1, V_F1, V_DEC, V_MEMADR, V_ADDIWB};
        op = '{6'h2B, 6'h2B, 6'h2B, 6'h2B, 6'h08, 6'h08, 6'h08, 6'h08};
        for (int i = 0; i < 8; i++) begin
            ready = 1'b1; opcode = op[i]; #1;
            n_checks++;
            if (outs_a !== ev[i]) begin n_fail++; $display("FAIL sw_addi cyc%0d got %h expected %h", i, outs_a, ev[i]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch();
        logic [18:0] ea [12];
        logic [18:0] eb [12];
        logic [5:0] op [12];
        bit z [12];
        ea = '{V_F1, V_DEC, V_BR_T, V_F1, V_DEC, V_BR_N, V_F1, V_DEC, V_BR_T, V_F1, V_DEC, V_BR_N};
        eb = '{V_F1, V_DEC, V_BR_T, V_F1, V_DEC, V_ILL,  V_F1, V_DEC, V_ILL,  V_F1, V_DEC, V_BR_N};
        op = '{6'h04, 6'h04, 6'h04, 6'h05, 6'h05, 6'h05, 6'h05, 6'h05, 6'h05, 6'h04, 6'h04, 6'h04};
        z  = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0};
        for (int i = 0; i < 12; i++) begin
            ready = 1'b1; opcode = op[i]; zero = z[i]; #1;
            n_checks++;
            if (outs_a !== ea[i]) begin n_fail++; $display("FAIL branch cyc%0d got %h expected %h", i, outs_a, ea[i]); end
            n_checks++;
            if (outs_b !== eb[i]) begin n_fail++; $display("FAIL branch_nobne cyc%0d got %h expected %h", i, outs_b, eb[i]); end
            @(posedge clk); #1;
        end
        zero = 1'b0;
    endtask

    task automatic test_illegal_jump();
        logic [18:0] ev [6];
        logic [5:0] op [6];
        ev = '{V_F1, V_DEC, V_ILL, V_F1, V_DEC, V_JUMP};
        op = '{6'h3F, 6'h3F, 6'h3F, 6'h02, 6'h02, 6'h02};
        for (int i = 0; i < 6; i++) begin
            ready = 1'b1; opcode = op[i]; #1;
            n_checks++;
            if (outs_a !== ev[i]) begin n_fail++; $display("FAIL illegal_jump cyc%0d got %h expected %h", i, outs_a, ev[i]); end
            @(posedge clk); #1;
        end
    endtask

    // ready arrives on the very cycle the counter reaches the limit
    task automatic test_ready_wins();
        logic [18:0] ev [8];
        bit rd [8];
        ev = '{V_F1, V_DEC, V_MEMADR, V_MW0, V_MW0, V_MW0, V_MW1, V_F1};
        rd = '{1, 1, 1, 0, 0, 0, 1, 1};
        opcode = 6'h2B;
        for (int i = 0; i < 8; i++) begin
            ready = rd[i]; #1;
            n_checks++;
            if (outs_a !== ev[i]) begin n_fail++; $display("FAIL ready_wins cyc%0d got %h expected %h", i, outs_a, ev[i]); end
            @(posedge clk); #1;
            if (i == 7) opcode = 6'h2B;
        end
    endtask

    task automatic test_timeout();
        logic [18:0] ev [9];
        bit rd [9];
        ev = '{V_DEC, V_MEMADR, V_MW0, V_MW0, V_MW0, V_MW0, V_ERR, V_ERR, V_ERR};
        rd = '{1, 1, 0, 0, 0, 0, 1, 1, 1};
        opcode = 6'h2B;
        for (int i = 0; i < 9; i++) begin
            ready = rd[i]; #1;
            n_checks++;
            if (outs_a !== ev[i]) begin n_fail++; $display("FAIL timeout cyc%0d got %h expected %h", i, outs_a, ev[i]); end
            @(posedge clk); #1;
        end
        rst_n = 1'b0; #1;
        n_checks++;
        if (outs_a !== 19'h0) begin n_fail++; $display("FAIL timeout_clear got %h expected %h", outs_a, 19'h0); end
        @(posedge clk); #1;
        rst_n = 1'b1; #1;
        n_checks++;
        if (outs_a !== 19'h0) begin n_fail++; $display("FAIL timeout_start got %h expected %h", outs_a, 19'h0); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_memrd();
        logic [18:0] ev [4];
        bit rd [4];
        ev = '{V_F1, V_DEC, V_MEMADR, V_MR};
        rd = '{1, 1, 1, 0};
        opcode = 6'h23;
        for (int i = 0; i < 4; i++) begin
            ready = rd[i]; #1;
            n_checks++;
            if (outs_a !== ev[i]) begin n_fail++; $display("FAIL mid_memrd cyc%0d got %h expected %h", i, outs_a, ev[i]); end
            @(posedge clk); #1;
        end
        ready = 1'b0; #1;
        n_checks++;
        if (outs_a !== V_MR) begin n_fail++; $display("FAIL mid_memrd_pre got %h expected %h", outs_a, V_MR); end
        rst_n = 1'b0; #1;
        n_checks++;
        if (outs_a !== 19'h0) begin n_fail++; $display("FAIL mid_memrd_async got %h expected %h", outs_a, 19'h0); end
        @(posedge clk); #1;
        rst_n = 1'b1; ready = 1'b1; #1;
        n_checks++;
        if (outs_a !== 19'h0) begin n_fail++; $display("FAIL mid_memrd_start got %h expected %h", outs_a, 19'h0); end
        @(posedge clk); #1;
        ready = 1'b0; #1;
        n_checks++;
        if (outs_a !== V_F0) begin n_fail++; $display("FAIL mid_memrd_fetch0 got %h expected %h", outs_a, V_F0); end
        @(posedge clk); #1;
        ready = 1'b1; #1;
        n_checks++;
        if (outs_a !== V_F1) begin n_fail++; $display("FAIL mid_memrd_fetch1 got %h expected %h", outs_a, V_F1); end
    endtask

    initial begin
        //           mr mw io irw pcw ps asa asb aop ext rw rd m2r ret ill be
        V_F0     = pk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        V_F1     = pk(1, 0, 0, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        V_DEC    = pk(0, 0, 0, 0, 0, 0, 0, 3, 0, 1, 0, 0, 0, 0, 0, 0);
        V_EXEC   = pk(0, 0, 0, 0, 0, 0, 1, 0, 2, 0, 0, 0, 0, 0, 0, 0);
        V_ALUWB  = pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0);
        V_MEMADR = pk(0, 0, 0, 0, 0, 0, 1, 2, 0, 1, 0, 0, 0, 0, 0, 0);
        V_MR     = pk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        V_MEMWB  = pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0);
        V_MW0    = pk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        V_MW1    = pk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        V_ADDIWB = pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0);
        V_BR_T   = pk(0, 0, 0, 0, 1, 1, 1, 0, 1, 0, 0, 0, 0, 1, 0, 0);
        V_BR_N   = pk(0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 1, 0, 0);
        V_JUMP   = pk(0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        V_ILL    = pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        V_ERR    = pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

        test_reset();
        test_rtype();
        test_lw_wait();
        test_sw_addi();
        test_branch();
        test_illegal_jump();
        test_ready_wins();
        test_timeout();
        test_reset_mid_memrd();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before end of sequence");
        $fatal(1, "watchdog");
    end

endmodule
